riscv_branch_predictor: RTL and testbench

- Next-generation branch hazard unit. Replaces the static always-not-taken scheme with a dynamic predictor: a direct-mapped BTB plus a 2-bit saturating-counter BHT.
- Looked up combinationally in IF. Resolved and updated in MEM, where it drives the flush and redirect PC.
- Parametrised in PC width, table depth and performance-counter width.
- Exports branch and mispredict counts for performance measurement.

---
 rtl/riscv_define.sv | 22 ++
 rtl/riscv_sat_counter2.sv | 19 +
 rtl/riscv_branch_predictor.sv | 141 ++++++++++++++
 tb/tb_riscv_branch_predictor.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_define.sv
// Shared encodings for the branch predictor: BranchOp codes and 2-bit counter states.
package riscv_define;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_JAL  = 3'b001;
  localparam logic [2:0] BR_JALR = 3'b010;
  localparam logic [2:0] BR_BEQ  = 3'b100;
  localparam logic [2:0] BR_BNE  = 3'b101;
  localparam logic [2:0] BR_BLT  = 3'b110;
  localparam logic [2:0] BR_BGE  = 3'b111;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // True for any op that resolves as a control transfer; undefined codes act as none.
  function automatic logic is_ctrl_op(input logic [2:0] op);
    return (op == BR_JAL) || (op == BR_JALR) || op[2];
  endfunction

endpackage

// File: rtl/riscv_sat_counter2.sv
// 2-bit saturating up/down counter next-state function.
module riscv_sat_counter2
  import riscv_define::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != ST) ctr_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != SNT) ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/riscv_branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB with 2-bit BHT, looked up in IF and
// resolved/updated in MEM, with branch and mispredict performance counters.
module riscv_branch_predictor
  import riscv_define::*;
#(
  parameter int unsigned PC_W     = 32,
  parameter int unsigned IDX_W    = 6,
  parameter int unsigned TAG_W    = PC_W - IDX_W - 2,
  parameter int unsigned CNT_W    = 32,
  parameter logic [1:0]  CTR_INIT = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PC_W-1:0]  if_pc_i,
  output logic             pred_taken_o,
  output logic [PC_W-1:0]  pred_target_o,
  input  logic             mem_valid_i,
  input  logic [PC_W-1:0]  mem_pc_i,
  input  logic [2:0]       BranchOp_i,
  input  logic             zero_i,
  input  logic             less_i,
  input  logic [PC_W-1:0]  mem_target_i,
  input  logic             mem_pred_taken_i,
  input  logic [PC_W-1:0]  mem_pred_target_i,
  output logic             flush_o,
  output logic [PC_W-1:0]  redirect_pc_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam int unsigned Depth = 1 << IDX_W;

  logic [Depth-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q    [Depth];
  logic [TAG_W-1:0] tag_d    [Depth];
  logic [PC_W-1:0]  target_q [Depth];
  logic [PC_W-1:0]  target_d [Depth];
  logic [1:0]       ctr_q    [Depth];
  logic [1:0]       ctr_d    [Depth];
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0] if_idx, mem_idx;
  logic [TAG_W-1:0] if_tag, mem_tag;
  logic             if_hit, mem_hit;
  logic             resolve, is_cond, actual_taken, mispredict;
  logic [PC_W-1:0]  pc_plus4;
  logic [1:0]       ctr_upd;
  logic             unused_pc_bits;

  assign if_idx  = if_pc_i[IDX_W+1:2];
  assign if_tag  = if_pc_i[PC_W-1:IDX_W+2];
  assign mem_idx = mem_pc_i[IDX_W+1:2];
  assign mem_tag = mem_pc_i[PC_W-1:IDX_W+2];
  assign unused_pc_bits = ^{if_pc_i[1:0], mem_pc_i[1:0]};

  // Lookup reads only the registered table, so a same-cycle update is not bypassed.
  always_comb begin
    if_hit        = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    pred_taken_o  = if_hit && ctr_q[if_idx][1];
    pred_target_o = pred_taken_o ? target_q[if_idx] : '0;
  end

  always_comb begin
    actual_taken = 1'b0;
    case (BranchOp_i)
      BR_JAL, BR_JALR: actual_taken = 1'b1;
      BR_BEQ:          actual_taken = zero_i;
      BR_BNE:          actual_taken = !zero_i;
      BR_BLT:          actual_taken = less_i;
      BR_BGE:          actual_taken = !less_i;
      default:         actual_taken = 1'b0;
    endcase
    resolve    = mem_valid_i && is_ctrl_op(BranchOp_i);
    is_cond    = BranchOp_i[2];
    mem_hit    = valid_q[mem_idx] && (tag_q[mem_idx] == mem_tag);
    mispredict = resolve &&
                 ((actual_taken != mem_pred_taken_i) ||
                  (actual_taken && mem_pred_taken_i && (mem_pred_target_i != mem_target_i)));
    pc_plus4      = mem_pc_i + PC_W'(4);
    flush_o       = mispredict && !rst;
    redirect_pc_o = (resolve && actual_taken) ? mem_target_i : pc_plus4;
  end

  riscv_sat_counter2 u_sat_counter (
    .ctr_i   (ctr_q[mem_idx]),
    .taken_i (actual_taken),
    .ctr_o   (ctr_upd)
  );

  always_comb begin
    valid_d       = valid_q;
    tag_d         = tag_q;
    target_d      = target_q;
    ctr_d         = ctr_q;
    branch_cnt_d  = branch_cnt_q + CNT_W'(resolve);
    mispred_cnt_d = mispred_cnt_q + CNT_W'(mispredict);
    if (resolve) begin
      if (is_cond) begin
        if (mem_hit) begin
          ctr_d[mem_idx] = ctr_upd;
          if (actual_taken) target_d[mem_idx] = mem_target_i;
        end else if (actual_taken) begin
          valid_d[mem_idx]  = 1'b1;
          tag_d[mem_idx]    = mem_tag;
          target_d[mem_idx] = mem_target_i;
          ctr_d[mem_idx]    = WT;
        end
      end else if (BranchOp_i == BR_JAL) begin
        valid_d[mem_idx]  = 1'b1;
        tag_d[mem_idx]    = mem_tag;
        target_d[mem_idx] = mem_target_i;
        ctr_d[mem_idx]    = ST;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q       <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_INIT;
      end
    end else begin
      valid_q       <= valid_d;
      tag_q         <= tag_d;
      target_q      <= target_d;
      ctr_q         <= ctr_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_cnt_o  = branch_cnt_q;
  assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_riscv_branch_predictor.sv
// Directed self-checking bench for riscv_branch_predictor with hand-computed expectations.
module tb_riscv_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc_i;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        mem_valid_i;
  logic [31:0] mem_pc_i;
  logic [2:0]  branch_op;
  logic        zero_i, less_i;
  logic [31:0] mem_target_i;
  logic        mem_pred_taken_i;
  logic [31:0] mem_pred_target_i;
  logic        flush_o;
  logic [31:0] redirect_pc_o;
  logic [31:0] branch_cnt_o, mispred_cnt_o;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  riscv_branch_predictor dut (
    .clk               (clk),
    .rst               (rst),
    .if_pc_i           (if_pc_i),
    .pred_taken_o      (pred_taken_o),
    .pred_target_o     (pred_target_o),
    .mem_valid_i       (mem_valid_i),
    .mem_pc_i          (mem_pc_i),
    .BranchOp_i        (branch_op),
    .zero_i            (zero_i),
    .less_i            (less_i),
    .mem_target_i      (mem_target_i),
    .mem_pred_taken_i  (mem_pred_taken_i),
    .mem_pred_target_i (mem_pred_target_i),
    .flush_o           (flush_o),
    .redirect_pc_o     (redirect_pc_o),
    .branch_cnt_o      (branch_cnt_o),
    .mispred_cnt_o     (mispred_cnt_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_mem(input logic v, input logic [2:0] op, input logic [31:0] pc,
                           input logic [31:0] tgt, input logic z, input logic l,
                           input logic pt, input logic [31:0] ptg);
    mem_valid_i = v; branch_op = op; mem_pc_i = pc; mem_target_i = tgt;
    zero_i = z; less_i = l; mem_pred_taken_i = pt; mem_pred_target_i = ptg;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_pc_i = 32'h100;
    drive_mem(1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick(); tick();
    rst = 1'b0;
    #1;
    tests_run++; if (pred_taken_o !== 1'b0) begin tests_failed++; $display("FAIL reset_pred_taken: got %b expected 0", pred_taken_o); end
    tests_run++; if (pred_target_o !== 32'h0) begin tests_failed++; $display("FAIL reset_pred_target: got %h expected 0", pred_target_o); end
    tests_run++; if (branch_cnt_o !== 32'd0) begin tests_failed++; $display("FAIL reset_branch_cnt: got %0d expected 0", branch_cnt_o); end
    tests_run++; if (mispred_cnt_o !== 32'd0) begin tests_failed++; $display("FAIL reset_mispred_cnt: got %0d expected 0", mispred_cnt_o); end
    tests_run++; if (flush_o !== 1'b0 || redirect_pc_o !== 32'h4) begin tests_failed++; $display("FAIL reset_idle_mem: got flush=%b redirect=%h expected 0/00000004", flush_o, redirect_pc_o); end
  endtask

  task automatic test_beq_learn();
    tick();
    if_pc_i = 32'h100;
    drive_mem(1'b1, 3'b100, 32'h100, 32'h80, 1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    tests_run++; if (pred_taken_o !== 1'b0) begin tests_failed++; $display("FAIL learn_pre_update_lookup: got %b expected 0", pred_taken_o); end
    tests_run++; if (flush_o !== 1'b1 || redirect_pc_o !== 32'h80) begin tests_failed++; $display("FAIL learn_flush: got flush=%b redirect=%h expected 1/00000080", flush_o, redirect_pc_o); end
    tick();
    mem_valid_i = 1'b0;
    #1;
    tests_run++; if (branch_cnt_o !== 32'd1 || mispred_cnt_o !== 32'd1) begin tests_failed++; $display("FAIL learn_counts: got %0d/%0d expected 1/1", branch_cnt_o, mispred_cnt_o); end
    tests_run++; if (pred_taken_o !== 1'b1 || pred_target_o !== 32'h80) begin tests_failed++; $display("FAIL learn_lookup: got %b/%h expected 1/00000080", pred_taken_o, pred_target_o); end
  endtask

  task automatic test_loop();
    for (int i = 0; i < 3; i++) begin
      tick();
      drive_mem(1'b1, 3'b100, 32'h100, 32'h80, 1'b1, 1'b0, 1'b1, 32'h80);
      #1;
      tests_run++; if (flush_o !== 1'b0) begin tests_failed++; $display("FAIL loop_taken_noflush[%0d]: got %b expected 0", i, flush_o); end
    end
    tick();
    drive_mem(1'b1, 3'b100, 32'h100, 32'h80, 1'b0, 1'b0, 1'b1, 32'h80);
    #1;
    tests_run++; if (flush_o !== 1'b1 || redirect_pc_o !== 32'h104) begin tests_failed++; $display("FAIL loop_exit_flush: got flush=%b redirect=%h expected 1/00000104", flush_o, redirect_pc_o); end
    tick();
    mem_valid_i = 1'b0;
    #1;
    tests_run++; if (pred_taken_o !== 1'b1 || pred_target_o !== 32'h80) begin tests_failed++; $display("FAIL loop_still_taken: got %b/%h expected 1/00000080", pred_taken_o, pred_target_o); end
    tests_run++; if (branch_cnt_o !== 32'd5 || mispred_cnt_o !== 32'd2) begin tests_failed++; $display("FAIL loop_counts: got %0d/%0d expected 5/2", branch_cnt_o, mispred_cnt_o); end
  endtask

  task automatic test_jal();
    tick();
    drive_mem(1'b1, 3'b001, 32'h200, 32'h400, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    tests_run++; if (flush_o !== 1'b1 || redirect_pc_o !== 32'h400) begin tests_failed++; $display("FAIL jal_first_flush: got flush=%b redirect=%h expected 1/00000400", flush_o, redirect_pc_o); end
    tick();
    drive_mem(1'b1, 3'b001, 32'h200, 32'h400, 1'b0, 1'b0, 1'b1, 32'h400);
    if_pc_i = 32'h200;
    #1;
    tests_run++; if (pred_taken_o !== 1'b1 || pred_target_o !== 32'h400) begin tests_failed++; $display("FAIL jal_lookup: got %b/%h expected 1/00000400", pred_taken_o, pred_target_o); end
    tests_run++; if (flush_o !== 1'b0 || redirect_pc_o !== 32'h400) begin tests_failed++; $display("FAIL jal_exact_noflush: got flush=%b redirect=%h expected 0/00000400", flush_o, redirect_pc_o); end
    tick();
    mem_valid_i = 1'b0; if_pc_i = 32'h100;
    #1;
    tests_run++; if (pred_taken_o !== 1'b0) begin tests_failed++; $display("FAIL jal_evicts_alias: got %b expected 0", pred_taken_o); end
    tests_run++; if (branch_cnt_o !== 32'd7 || mispred_cnt_o !== 32'd3) begin tests_failed++; $display("FAIL jal_counts: got %0d/%0d expected 7/3", branch_cnt_o, mispred_cnt_o); end
  endtask

  task automatic test_jalr();
    for (int i = 0; i < 2; i++) begin
      tick();
      drive_mem(1'b1, 3'b010, 32'h300, 32'h500, 1'b0, 1'b0, 1'b0, 32'h0);
      #1;
      tests_run++; if (flush_o !== 1'b1 || redirect_pc_o !== 32'h500) begin tests_failed++; $display("FAIL jalr_flush[%0d]: got flush=%b redirect=%h expected 1/00000500", i, flush_o, redirect_pc_o); end
    end
    tick();
    mem_valid_i = 1'b0; if_pc_i = 32'h300;
    #1;
    tests_run++; if (pred_taken_o !== 1'b0) begin tests_failed++; $display("FAIL jalr_not_installed: got %b expected 0", pred_taken_o); end
    if_pc_i = 32'h200;
    #1;
    tests_run++; if (pred_taken_o !== 1'b1 || pred_target_o !== 32'h400) begin tests_failed++; $display("FAIL jalr_kept_jal: got %b/%h expected 1/00000400", pred_taken_o, pred_target_o); end
    tests_run++; if (branch_cnt_o !== 32'd9 || mispred_cnt_o !== 32'd5) begin tests_failed++; $display("FAIL jalr_counts: got %0d/%0d expected 9/5", branch_cnt_o, mispred_cnt_o); end
  endtask

  task automatic test_alias();
    tick();
    drive_mem(1'b1, 3'b100, 32'h100, 32'h180, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    drive_mem(1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    if_pc_i = 32'h100;
    #1;
    tests_run++; if (pred_taken_o !== 1'b1 || pred_target_o !== 32'h180) begin tests_failed++; $display("FAIL alias_first_install: got %b/%h expected 1/00000180", pred_taken_o, pred_target_o); end
    drive_mem(1'b1, 3'b101, 32'h200, 32'h280, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    drive_mem(1'b1, 3'b110, 32'h104, 32'h20, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    tests_run++; if (pred_taken_o !== 1'b0) begin tests_failed++; $display("FAIL alias_evicted: got %b expected 0", pred_taken_o); end
    tests_run++; if (flush_o !== 1'b0 || redirect_pc_o !== 32'h108) begin tests_failed++; $display("FAIL blt_not_taken: got flush=%b redirect=%h expected 0/00000108", flush_o, redirect_pc_o); end
    tick();
    drive_mem(1'b1, 3'b111, 32'h108, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0);
    if_pc_i = 32'h200;
    #1;
    tests_run++; if (pred_taken_o !== 1'b1 || pred_target_o !== 32'h280) begin tests_failed++; $display("FAIL alias_second_install: got %b/%h expected 1/00000280", pred_taken_o, pred_target_o); end
    tests_run++; if (flush_o !== 1'b1 || redirect_pc_o !== 32'h40) begin tests_failed++; $display("FAIL bge_taken: got flush=%b redirect=%h expected 1/00000040", flush_o, redirect_pc_o); end
    tick();
    mem_valid_i = 1'b0; if_pc_i = 32'h104;
    #1;
    tests_run++; if (pred_taken_o !== 1'b0) begin tests_failed++; $display("FAIL blt_no_install: got %b expected 0", pred_taken_o); end
    if_pc_i = 32'h108;
    #1;
    tests_run++; if (pred_taken_o !== 1'b1 || pred_target_o !== 32'h40) begin tests_failed++; $display("FAIL bge_install: got %b/%h expected 1/00000040", pred_taken_o, pred_target_o); end
    tests_run++; if (branch_cnt_o !== 32'd13 || mispred_cnt_o !== 32'd8) begin tests_failed++; $display("FAIL alias_counts: got %0d/%0d expected 13/8", branch_cnt_o, mispred_cnt_o); end
  endtask

  task automatic test_invalid();
    tick();
    drive_mem(1'b0, 3'b100, 32'h100, 32'h999, 1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    tests_run++; if (flush_o !== 1'b0 || redirect_pc_o !== 32'h104) begin tests_failed++; $display("FAIL invalid_noflush: got flush=%b redirect=%h expected 0/00000104", flush_o, redirect_pc_o); end
    tick();
    drive_mem(1'b1, 3'b011, 32'hFFFF_FFFC, 32'h999, 1'b1, 1'b0, 1'b1, 32'h0);
    if_pc_i = 32'h100;
    #1;
    tests_run++; if (flush_o !== 1'b0 || redirect_pc_o !== 32'h0) begin tests_failed++; $display("FAIL undefined_op_wrap: got flush=%b redirect=%h expected 0/00000000", flush_o, redirect_pc_o); end
    tests_run++; if (pred_taken_o !== 1'b0) begin tests_failed++; $display("FAIL invalid_no_install: got %b expected 0", pred_taken_o); end
    tick();
    mem_valid_i = 1'b0;
    #1;
    tests_run++; if (branch_cnt_o !== 32'd13 || mispred_cnt_o !== 32'd8) begin tests_failed++; $display("FAIL invalid_counts: got %0d/%0d expected 13/8", branch_cnt_o, mispred_cnt_o); end
  endtask

  task automatic test_reset_mid();
    tick();
    drive_mem(1'b1, 3'b100, 32'h200, 32'h600, 1'b1, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    #1;
    tests_run++; if (flush_o !== 1'b0) begin tests_failed++; $display("FAIL rst_masks_flush: got %b expected 0", flush_o); end
    tick();
    rst = 1'b0; mem_valid_i = 1'b0; if_pc_i = 32'h200;
    #1;
    tests_run++; if (pred_taken_o !== 1'b0 || pred_target_o !== 32'h0) begin tests_failed++; $display("FAIL rst_clears_entry: got %b/%h expected 0/00000000", pred_taken_o, pred_target_o); end
    if_pc_i = 32'h108;
    #1;
    tests_run++; if (pred_taken_o !== 1'b0) begin tests_failed++; $display("FAIL rst_clears_other: got %b expected 0", pred_taken_o); end
    tests_run++; if (branch_cnt_o !== 32'd0 || mispred_cnt_o !== 32'd0) begin tests_failed++; $display("FAIL rst_counts: got %0d/%0d expected 0/0", branch_cnt_o, mispred_cnt_o); end
  endtask

  initial begin
    test_reset();
    test_beq_learn();
    test_loop();
    test_jal();
    test_jalr();
    test_alias();
    test_invalid();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
